// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg
//   Shared types and constants for the March C- RAM BIST controller.
//   - bist_state_e  : controller FSM states
//   - march_elem_t  : one March element (direction, read/expect, write/value)
//   - march_elem()  : element table indexed by phase
//   - NUM_PHASES    : number of March elements in the sequence
//   - ERR_SAT       : saturation value of the mismatch counter
package ram_bist_pkg;

  localparam int PHASE_W = 3;
  localparam logic [PHASE_W-1:0] NUM_PHASES = 3'd6;
  localparam logic [7:0] ERR_SAT = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } bist_state_e;

  // rd_inv / wr_inv select the inverted background (~BG) instead of BG.
  typedef struct packed {
    logic down;
    logic has_rd;
    logic rd_inv;
    logic has_wr;
    logic wr_inv;
  } march_elem_t;

  // March C-: {up W0} {up R0 W1} {up R1 W0} {down R0 W1} {down R1 W0} {up R0}
  function automatic march_elem_t march_elem(input logic [PHASE_W-1:0] phase);
    march_elem_t e;
    case (phase)
      3'd0:    e = '{down: 1'b0, has_rd: 1'b0, rd_inv: 1'b0, has_wr: 1'b1, wr_inv: 1'b0};
      3'd1:    e = '{down: 1'b0, has_rd: 1'b1, rd_inv: 1'b0, has_wr: 1'b1, wr_inv: 1'b1};
      3'd2:    e = '{down: 1'b0, has_rd: 1'b1, rd_inv: 1'b1, has_wr: 1'b1, wr_inv: 1'b0};
      3'd3:    e = '{down: 1'b1, has_rd: 1'b1, rd_inv: 1'b0, has_wr: 1'b1, wr_inv: 1'b1};
      3'd4:    e = '{down: 1'b1, has_rd: 1'b1, rd_inv: 1'b1, has_wr: 1'b1, wr_inv: 1'b0};
      3'd5:    e = '{down: 1'b0, has_rd: 1'b1, rd_inv: 1'b0, has_wr: 1'b0, wr_inv: 1'b0};
      default: e = '{down: 1'b0, has_rd: 1'b0, rd_inv: 1'b0, has_wr: 1'b0, wr_inv: 1'b0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ram_bist_ctrl_if.sv
// ram_bist_ctrl_if
//   Groups the BIST control/status signals and the RAM port it drives.
//   master : the BIST controller (drives status and RAM we/addr/din)
//   slave  : the surrounding system (drives start, returns RAM dout)
interface ram_bist_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [7:0]    err_count;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport master (
    input  start, ram_dout,
    output busy, done, pass, fail_addr, fail_data, err_count,
           ram_we, ram_addr, ram_din
  );

  modport slave (
    output start, ram_dout,
    input  busy, done, pass, fail_addr, fail_data, err_count,
           ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen
//   Up/down address counter for the March sequence.
//   load_i      : load start address of a new element (0 when up, max when down)
//   load_down_i : direction of the element being loaded
//   step_i      : advance one address in the latched direction
//   addr_o      : current address (registered)
//   last_o      : current address is the final one of the element
module ram_bist_addr_gen #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          load_down_i,
  input  logic          step_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_MAX  = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] addr_q, addr_d;
  logic          down_q, down_d;

  // Next address: load has priority over step.
  always_comb begin
    addr_d = addr_q;
    down_d = down_q;
    if (load_i) begin
      down_d = load_down_i;
      addr_d = load_down_i ? ADDR_MAX : ADDR_ZERO;
    end else if (step_i) begin
      addr_d = down_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
    end else begin
      addr_d = addr_q;
    end
  end

  // Address and direction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= ADDR_ZERO;
      down_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      down_q <= down_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = down_q ? (addr_q == ADDR_ZERO) : (addr_q == ADDR_MAX);

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl
//   March C- self-test engine placed in front of a synchronous RAM.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus.start  : run request, honoured only in IDLE
//   bus.busy/done/pass/fail_addr/fail_data/err_count : run status
//   bus.ram_we/ram_addr/ram_din : RAM write/address/data, decoded only from
//                 state, phase and address registers
//   bus.ram_dout : RAM read data, valid in the cycle after a read address
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int            AW = 4,
  parameter int            DW = 8,
  parameter logic [DW-1:0] BG = 8'h00
) (
  input logic         clk,
  input logic         rst_n,
  ram_bist_ctrl_if.master bus
);

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

  bist_state_e          state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [AW-1:0]        fail_addr_q, fail_addr_d;
  logic [DW-1:0]        fail_data_q, fail_data_d;
  logic [7:0]           err_count_q, err_count_d;

  logic                 addr_load_s, addr_load_down_s, addr_step_s;
  logic [AW-1:0]        addr_s;
  logic                 addr_last_s;
  march_elem_t          cur_elem_s, nxt_elem_s;
  logic [DW-1:0]        rd_exp_s, wr_val_s, diff_s;
  logic                 mismatch_s;

  ram_bist_addr_gen #(.AW(AW)) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (addr_load_s),
    .load_down_i (addr_load_down_s),
    .step_i      (addr_step_s),
    .addr_o      (addr_s),
    .last_o      (addr_last_s)
  );

  // Element decode and read comparison for the current phase.
  always_comb begin
    cur_elem_s = march_elem(phase_q);
    nxt_elem_s = march_elem(phase_q + 3'd1);
    rd_exp_s   = cur_elem_s.rd_inv ? ~BG : BG;
    wr_val_s   = cur_elem_s.wr_inv ? ~BG : BG;
    diff_s     = bus.ram_dout ^ rd_exp_s;
    mismatch_s = (state_q == ST_CMP) && cur_elem_s.has_rd && (diff_s != DATA_ZERO);
  end

  // RAM port decode: the compare cycle doubles as the write-back cycle.
  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = ADDR_ZERO;
    bus.ram_din  = DATA_ZERO;
    case (state_q)
      ST_WR: begin
        bus.ram_we   = 1'b1;
        bus.ram_addr = addr_s;
        bus.ram_din  = wr_val_s;
      end
      ST_RD: begin
        bus.ram_addr = addr_s;
      end
      ST_CMP: begin
        bus.ram_addr = addr_s;
        if (cur_elem_s.has_wr) begin
          bus.ram_we  = 1'b1;
          bus.ram_din = wr_val_s;
        end else begin
          bus.ram_we  = 1'b0;
        end
      end
      default: begin
        bus.ram_we = 1'b0;
      end
    endcase
  end

  // Next-state, sequencing and result bookkeeping.
  always_comb begin
    state_d          = state_q;
    phase_d          = phase_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    fail_addr_d      = fail_addr_q;
    fail_data_d      = fail_data_q;
    err_count_d      = err_count_q;
    addr_load_s      = 1'b0;
    addr_load_down_s = 1'b0;
    addr_step_s      = 1'b0;

    // A zero counter means no earlier mismatch in this run, since the
    // counter only ever grows until the next start clears it.
    if (mismatch_s) begin
      if (err_count_q == 8'd0) begin
        fail_addr_d = addr_s;
        fail_data_d = diff_s;
      end else begin
        fail_addr_d = fail_addr_q;
      end
      if (err_count_q != ERR_SAT) begin
        err_count_d = err_count_q + 8'd1;
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      err_count_d = err_count_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d          = ST_WR;
          phase_d          = 3'd0;
          addr_load_s      = 1'b1;
          addr_load_down_s = march_elem(3'd0).down;
          busy_d           = 1'b1;
          pass_d           = 1'b0;
          fail_addr_d      = ADDR_ZERO;
          fail_data_d      = DATA_ZERO;
          err_count_d      = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (addr_last_s) begin
          phase_d          = phase_q + 3'd1;
          addr_load_s      = 1'b1;
          addr_load_down_s = nxt_elem_s.down;
          state_d          = nxt_elem_s.has_rd ? ST_RD : ST_WR;
        end else begin
          addr_step_s = 1'b1;
        end
      end
      ST_RD: begin
        state_d = ST_CMP;
      end
      ST_CMP: begin
        if (addr_last_s) begin
          if (phase_q == (NUM_PHASES - 3'd1)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Uses the updated count so a mismatch on the final read counts.
            pass_d  = (err_count_d == 8'd0);
          end else begin
            phase_d          = phase_q + 3'd1;
            addr_load_s      = 1'b1;
            addr_load_down_s = nxt_elem_s.down;
            state_d          = nxt_elem_s.has_rd ? ST_RD : ST_WR;
          end
        end else begin
          addr_step_s = 1'b1;
          state_d     = ST_RD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= ADDR_ZERO;
      fail_data_q <= DATA_ZERO;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_data = fail_data_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl
//   Bench for ram_bist_ctrl with a behavioural RAM that can carry a stuck-at
//   fault. Expected run results come from an abstract March C- walk over an
//   array; a monitor pops them whenever done pulses.
module tb_ram_bist_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam logic [7:0] BG = 8'h00;
  localparam int RUN_CYC = 176;
  localparam int PERIOD = 178;

  typedef struct packed {
    logic       pass;
    logic [3:0] fa;
    logic [7:0] fd;
    logic [7:0] ec;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ram_bist_ctrl_if #(.AW(AW), .DW(DW)) bus ();
  ram_bist_ctrl #(.AW(AW), .DW(DW), .BG(BG)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // March C- described as plain tables.
  bit el_dn[6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  bit el_rd[6]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  bit el_rinv[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  bit el_wr[6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit el_winv[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  // Fault configuration
  bit         f_en = 1'b0, f_all = 1'b0, f_val = 1'b0;
  int         f_bit = 0;
  logic [3:0] f_addr = 4'h0;

  logic [7:0] mem [DEPTH];
  exp_t       sb[$];
  int         done_cyc[$];
  int         n_vec = 0, n_err = 0, done_cnt = 0, cyc = 0, busy_cnt = 0;

  function automatic logic [7:0] faulty(input logic [7:0] v, input logic [3:0] a);
    logic [7:0] r;
    r = v;
    if (f_en && (f_all || a == f_addr)) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= faulty(mem[bus.ram_addr], bus.ram_addr);
  end

  function automatic exp_t model();
    logic [7:0] m [DEPTH];
    logic [7:0] obs, ex;
    exp_t r;
    int cnt, a;
    r = '0;
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) m[i] = 8'h00;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < DEPTH; k++) begin
        a = el_dn[e] ? DEPTH - 1 - k : k;
        if (el_rd[e]) begin
          obs = faulty(m[a], 4'(a));
          ex = el_rinv[e] ? ~BG : BG;
          if (obs != ex) begin
            if (cnt == 0) begin
              r.fa = 4'(a);
              r.fd = obs ^ ex;
            end
            cnt++;
          end
        end
        if (el_wr[e]) m[a] = el_winv[e] ? ~BG : BG;
      end
    end
    r.ec = 8'((cnt > 255) ? 255 : cnt);
    r.pass = (cnt == 0);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: counts busy cycles and scores each completed run.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("pass", 32'(bus.pass), 32'(e.pass));
          check("fail_addr", 32'(bus.fail_addr), 32'(e.fa));
          check("fail_data", 32'(bus.fail_data), 32'(e.fd));
          check("err_count", 32'(bus.err_count), 32'(e.ec));
          check("busy_len", 32'(busy_cnt), 32'(RUN_CYC));
          check("busy_at_done", 32'(bus.busy), 32'd0);
        end
        done_cnt++;
        done_cyc.push_back(cyc);
        busy_cnt = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_pass"}, 32'(bus.pass), 32'd0);
    check({tag, "_err"}, 32'(bus.err_count), 32'd0);
    check({tag, "_faddr"}, 32'(bus.fail_addr), 32'd0);
    check({tag, "_fdata"}, 32'(bus.fail_data), 32'd0);
    check({tag, "_we"}, 32'(bus.ram_we), 32'd0);
    check({tag, "_addr"}, 32'(bus.ram_addr), 32'd0);
    check({tag, "_din"}, 32'(bus.ram_din), 32'd0);
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(posedge clk);
    if (done_cnt < target) begin
      n_vec++;
      n_err++;
      $display("FAIL run_timeout: done count %0d expected %0d", done_cnt, target);
      sb.delete();
    end
  endtask

  task automatic do_run(input exp_t e, input bit noise);
    int d0;
    sb.push_back(e);
    d0 = done_cnt;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    if (noise) begin
      repeat (5) @(posedge clk);
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); #1 bus.start = 1'($urandom_range(0, 1));
      end
      bus.start = 1'b0;
    end
    wait_done(d0 + 1, 400);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int d0, nrun, base;
    bus.start = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Clean run and backdoor readout
    do_run('{pass: 1'b1, fa: 4'h0, fd: 8'h00, ec: 8'd0}, 1'b0);
    for (int i = 0; i < DEPTH; i++) check("backdoor", 32'(mem[i]), 32'(BG));

    // Stuck-at-1 bit 3 at address 5
    f_en = 1'b1; f_all = 1'b0; f_addr = 4'h5; f_bit = 3; f_val = 1'b1;
    do_run('{pass: 1'b0, fa: 4'h5, fd: 8'h08, ec: 8'd3}, 1'b0);

    // Stuck-at-0 bit 0 at address F
    f_addr = 4'hF; f_bit = 0; f_val = 1'b0;
    do_run('{pass: 1'b0, fa: 4'hF, fd: 8'h01, ec: 8'd2}, 1'b0);

    // Reset in the middle of M2
    f_addr = 4'h2; f_bit = 3; f_val = 1'b1;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (59) @(posedge clk);
    #3;
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    check("pre_rst_err", 32'(bus.err_count), 32'd1);
    check("pre_rst_faddr", 32'(bus.fail_addr), 32'h2);
    rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    f_en = 1'b0;
    do_run('{pass: 1'b1, fa: 4'h0, fd: 8'h00, ec: 8'd0}, 1'b0);

    // Randomised fault runs, some with start noise while busy
    for (int r = 0; r < 12; r++) begin
      f_en = ($urandom_range(0, 3) != 0);
      f_all = ($urandom_range(0, 3) == 0);
      f_addr = 4'($urandom_range(0, DEPTH - 1));
      f_bit = $urandom_range(0, 7);
      f_val = 1'($urandom_range(0, 1));
      e = model();
      do_run(e, 1'($urandom_range(0, 1)));
    end

    // start held high: back-to-back runs
    f_en = 1'b0;
    d0 = done_cnt;
    nrun = 0;
    for (int t = 0; t < 400; t += PERIOD) begin
      sb.push_back('{pass: 1'b1, fa: 4'h0, fd: 8'h00, ec: 8'd0});
      nrun++;
    end
    @(posedge clk); #1 bus.start = 1'b1;
    repeat (400) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(d0 + nrun, 1000);
    if (done_cnt >= d0 + nrun) begin
      base = done_cyc.size() - nrun;
      for (int k = 0; k + 1 < nrun; k++)
        check("run_gap", 32'(done_cyc[base + k + 1] - done_cyc[base + k]), 32'(PERIOD));
    end
    repeat (5) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
